// File: rtl/fattree_upport_allocator.sv
// fattree_upport_allocator: per-router up-port allocation for k-ary n-tree NoC.
// Picks one of K up ports per climbing packet, holds it until the tail
// leaves, and tracks how many packets are locked on each up port.
//
// Parameters:
//   K     number of up ports (2..16)
//   P_IN  number of requesting input ports (normally 2K)
//   MODE  "RR" rotating choice, "LOAD" least-loaded choice
//   Kw    up-port index width, LDw load counter width
//
// Ports:
//   clk, reset   clock, synchronous active-high reset
//   hdr_req      per input: head flit waiting for an up port
//   tail_done    per input: one-cycle pulse when the tail has left
//   up_sel       per input: Kw-bit up-port index (physical port K+index)
//   sel_valid    per input: assignment is locked
//   port_load    per up port: LDw-bit count of locked packets
//   alloc_err    sticky: tail_done seen on an idle input
//   stat_grants  per up port: 32-bit grant counter
//
// Optional: define FATTREE_UPALLOC_STAT_EN to build the grant counters;
// otherwise stat_grants is tied to zero.

module fattree_upport_allocator #(
   parameter int    K    = 2,
   parameter int    P_IN = 4,
   parameter string MODE = "RR",
   parameter int    Kw   = (K > 1) ? $clog2(K) : 1,
   parameter int    LDw  = $clog2(P_IN + 1)
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [P_IN-1:0]     hdr_req,
   input  logic [P_IN-1:0]     tail_done,
   output logic [P_IN*Kw-1:0]  up_sel,
   output logic [P_IN-1:0]     sel_valid,
   output logic [K*LDw-1:0]    port_load,
   output logic                alloc_err,
   output logic [K*32-1:0]     stat_grants
);

   localparam int PW = (P_IN > 1) ? $clog2(P_IN) : 1;
   localparam logic [PW:0] PN = (PW+1)'(P_IN);
   localparam logic [Kw:0] KN = (Kw+1)'(K);

   typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_e;

   state_e          st_q     [P_IN];
   logic [Kw-1:0]   up_sel_q [P_IN];
   logic [LDw-1:0]  load_q   [K];
   logic [LDw-1:0]  load_d   [K];
   logic [LDw-1:0]  dec_cnt  [K];
   int              ld_chk   [K];
   logic [PW-1:0]   in_ptr_q;
   logic [Kw-1:0]   up_ptr_q;
   logic            err_q;

   logic            gnt_vld;
   logic [PW-1:0]   gnt_idx;
   logic [Kw-1:0]   gnt_port;
   logic [P_IN-1:0] locked;

   // Offsets are always below the modulus, so one subtraction wraps.
   function automatic logic [PW-1:0] in_wrap(input logic [PW-1:0] b,
                                             input int off);
      logic [PW:0] s;
      s = {1'b0, b} + (PW+1)'(off);
      if (s >= PN) s = s - PN;
      return s[PW-1:0];
   endfunction

   function automatic logic [Kw-1:0] up_wrap(input logic [Kw-1:0] b,
                                             input int off);
      logic [Kw:0] s;
      s = {1'b0, b} + (Kw+1)'(off);
      if (s >= KN) s = s - KN;
      return s[Kw-1:0];
   endfunction

   always_comb begin
      for (int i = 0; i < P_IN; i++) locked[i] = (st_q[i] == LOCKED);
   end

   // Round-robin input arbiter over idle requesters, starting at in_ptr_q.
   always_comb begin
      logic [PW-1:0] c;
      gnt_vld = 1'b0;
      gnt_idx = '0;
      for (int off = 0; off < P_IN; off++) begin
         c = in_wrap(in_ptr_q, off);
         if (!gnt_vld && hdr_req[c] && !locked[c]) begin
            gnt_vld = 1'b1;
            gnt_idx = c;
         end
      end
   end

   generate
      if (MODE == "LOAD") begin : g_load
         // Strict '<' keeps the first minimum seen from the pointer.
         always_comb begin
            logic [Kw-1:0]  c;
            logic [LDw-1:0] best_ld;
            gnt_port = up_ptr_q;
            best_ld  = load_q[up_ptr_q];
            for (int off = 1; off < K; off++) begin
               c = up_wrap(up_ptr_q, off);
               if (load_q[c] < best_ld) begin
                  gnt_port = c;
                  best_ld  = load_q[c];
               end
            end
         end
      end else begin : g_rr
         assign gnt_port = up_ptr_q;
      end
   endgenerate

   // Releases are counted per port so several tails in one cycle
   // subtract together; a grant on the same port cancels one release.
   always_comb begin
      for (int j = 0; j < K; j++) begin
         dec_cnt[j] = '0;
         for (int i = 0; i < P_IN; i++) begin
            if (tail_done[i] && locked[i] && up_sel_q[i] == Kw'(j))
               dec_cnt[j] = dec_cnt[j] + LDw'(1);
         end
         load_d[j] = load_q[j]
                   + LDw'(gnt_vld && gnt_port == Kw'(j))
                   - dec_cnt[j];
         ld_chk[j] = int'(load_q[j])
                   + ((gnt_vld && gnt_port == Kw'(j)) ? 1 : 0)
                   - int'(dec_cnt[j]);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < P_IN; i++) begin
            st_q[i]     <= IDLE;
            up_sel_q[i] <= '0;
         end
         for (int j = 0; j < K; j++) load_q[j] <= '0;
         in_ptr_q <= '0;
         up_ptr_q <= '0;
         err_q    <= 1'b0;
      end else begin
         for (int i = 0; i < P_IN; i++) begin
            if (st_q[i] == LOCKED) begin
               if (tail_done[i]) st_q[i] <= IDLE;
            end else if (gnt_vld && gnt_idx == PW'(i)) begin
               st_q[i]     <= LOCKED;
               up_sel_q[i] <= gnt_port;
            end
         end
         for (int j = 0; j < K; j++) begin
            assert (ld_chk[j] >= 0 && ld_chk[j] <= P_IN)
               else $error("port_load %0d out of range", j);
            load_q[j] <= load_d[j];
         end
         if (gnt_vld) begin
            in_ptr_q <= in_wrap(gnt_idx, 1);
            up_ptr_q <= up_wrap(up_ptr_q, 1);
         end
         if (|(tail_done & ~locked)) err_q <= 1'b1;
      end
   end

   generate
      for (genvar i = 0; i < P_IN; i++) begin : g_out_in
         assign up_sel[i*Kw +: Kw] = up_sel_q[i];
         assign sel_valid[i]       = locked[i];
      end
      for (genvar j = 0; j < K; j++) begin : g_out_ld
         assign port_load[j*LDw +: LDw] = load_q[j];
      end
   endgenerate

   assign alloc_err = err_q;

`ifdef FATTREE_UPALLOC_STAT_EN
   logic [31:0] stat_q [K];

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int j = 0; j < K; j++) stat_q[j] <= '0;
      end else if (gnt_vld) begin
         stat_q[gnt_port] <= stat_q[gnt_port] + 32'd1;
      end
   end

   generate
      for (genvar j = 0; j < K; j++) begin : g_stat
         assign stat_grants[j*32 +: 32] = stat_q[j];
      end
   endgenerate
`else
   assign stat_grants = '0;
`endif

endmodule

// File: tb/tb_fattree_upport_allocator.sv
// tb_fattree_upport_allocator: scoreboard bench driving an RR and a LOAD
// instance with shared stimulus; directed checks plus a random phase.

module tb_fattree_upport_allocator;

   localparam int K   = 2;
   localparam int P   = 4;
   localparam int LDW = 3;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  hdr_req;
   logic [3:0]  tail_done;

   logic [3:0]  up_sel_rr, sel_valid_rr, up_sel_ld, sel_valid_ld;
   logic [5:0]  port_load_rr, port_load_ld;
   logic        alloc_err_rr, alloc_err_ld;
   logic [63:0] stat_rr, stat_ld;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   fattree_upport_allocator #(.K(K), .P_IN(P), .MODE("RR")) u_rr (
      .clk(clk), .reset(reset), .hdr_req(hdr_req), .tail_done(tail_done),
      .up_sel(up_sel_rr), .sel_valid(sel_valid_rr),
      .port_load(port_load_rr), .alloc_err(alloc_err_rr),
      .stat_grants(stat_rr)
   );

   fattree_upport_allocator #(.K(K), .P_IN(P), .MODE("LOAD")) u_ld (
      .clk(clk), .reset(reset), .hdr_req(hdr_req), .tail_done(tail_done),
      .up_sel(up_sel_ld), .sel_valid(sel_valid_ld),
      .port_load(port_load_ld), .alloc_err(alloc_err_ld),
      .stat_grants(stat_ld)
   );

   typedef struct packed {
      logic [3:0]  sv;
      logic [3:0]  us;
      logic [5:0]  pl;
      logic        err;
      logic [63:0] st;
   } snap_t;

   snap_t q_rr[$];
   snap_t q_ld[$];

   // Reference state, index 0 = RR, 1 = LOAD.
   int m_lk  [2][P];
   int m_us  [2][P];
   int m_ld  [2][K];
   int m_st  [2][K];
   int m_ip  [2];
   int m_upp [2];
   int m_err [2];

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_step(input int m, input logic rst,
                             input logic [3:0] h, input logic [3:0] t);
      int w;
      int p;
      int idx;
      int c;
      if (rst) begin
         for (int i = 0; i < P; i++) begin
            m_lk[m][i] = 0;
            m_us[m][i] = 0;
         end
         for (int j = 0; j < K; j++) begin
            m_ld[m][j] = 0;
            m_st[m][j] = 0;
         end
         m_ip[m] = 0; m_upp[m] = 0; m_err[m] = 0;
         return;
      end
      w = -1;
      p = m_upp[m];
      for (int off = 0; off < P; off++) begin
         idx = (m_ip[m] + off) % P;
         if (w < 0 && h[idx[1:0]] && m_lk[m][idx] == 0) w = idx;
      end
      if (w >= 0 && m == 1) begin
         for (int off = 1; off < K; off++) begin
            c = (m_upp[m] + off) % K;
            if (m_ld[m][c] < m_ld[m][p]) p = c;
         end
      end
      for (int i = 0; i < P; i++) begin
         if (t[i]) begin
            if (m_lk[m][i] != 0) begin
               m_ld[m][m_us[m][i]]--;
               m_lk[m][i] = 0;
            end else begin
               m_err[m] = 1;
            end
         end
      end
      if (w >= 0) begin
         m_lk[m][w] = 1;
         m_us[m][w] = p;
         m_ld[m][p]++;
         m_st[m][p]++;
         m_ip[m]  = (w + 1) % P;
         m_upp[m] = (m_upp[m] + 1) % K;
      end
   endtask

   function automatic snap_t mk_snap(input int m);
      snap_t s;
      int v;
      s = '0;
      for (int i = 0; i < P; i++) begin
         s.sv[i] = (m_lk[m][i] != 0);
         v = m_us[m][i];
         s.us[i] = v[0];
      end
      for (int j = 0; j < K; j++) begin
         v = m_ld[m][j];
         s.pl[j*LDW +: LDW] = v[2:0];
`ifdef FATTREE_UPALLOC_STAT_EN
         s.st[j*32 +: 32] = m_st[m][j];
`endif
      end
      s.err = (m_err[m] != 0);
      return s;
   endfunction

   task automatic cmp(input string nm, input snap_t e,
                      input logic [3:0] sv, input logic [3:0] us,
                      input logic [5:0] pl, input logic err,
                      input logic [63:0] st);
      chk({nm, "_sel_valid"}, 64'(sv), 64'(e.sv));
      chk({nm, "_up_sel"}, 64'(us), 64'(e.us));
      chk({nm, "_port_load"}, 64'(pl), 64'(e.pl));
      chk({nm, "_alloc_err"}, 64'(err), 64'(e.err));
      chk({nm, "_stat"}, st, e.st);
   endtask

   task automatic step(input logic rst, input logic [3:0] h,
                       input logic [3:0] t);
      reset     = rst;
      hdr_req   = h;
      tail_done = t;
      model_step(0, rst, h, t);
      model_step(1, rst, h, t);
      q_rr.push_back(mk_snap(0));
      q_ld.push_back(mk_snap(1));
      @(posedge clk);
      #1;
      cmp("rr", q_rr.pop_front(), sel_valid_rr, up_sel_rr,
          port_load_rr, alloc_err_rr, stat_rr);
      cmp("ld", q_ld.pop_front(), sel_valid_ld, up_sel_ld,
          port_load_ld, alloc_err_ld, stat_ld);
   endtask

   initial begin
      logic [3:0] h;
      logic [3:0] t;
      reset = 1'b1; hdr_req = '0; tail_done = '0;

      step(1, 4'b0000, 4'b0000);
      step(1, 4'b0000, 4'b0000);
      chk("reset_load", 64'(port_load_rr), 64'd0);
      chk("reset_valid", 64'(sel_valid_ld), 64'd0);

      // First RR grant: one-cycle latency.
      step(0, 4'b0001, 4'b0000);
      chk("rr_first_sel", 64'(up_sel_rr[0]), 64'd0);
      chk("rr_first_valid", 64'(sel_valid_rr), 64'b0001);
      chk("rr_first_load", 64'(port_load_rr), 64'b000_001);
      step(0, 4'b0000, 4'b0000);

      // Serialised grants with all requests held.
      step(1, 4'b0000, 4'b0000);
      for (int k = 0; k < 4; k++) begin
         step(0, 4'b1111, 4'b0000);
         chk("serial_valid", 64'(sel_valid_rr), 64'((1 << (k + 1)) - 1));
      end
      chk("serial_sel", 64'(up_sel_rr), 64'b1010);
      chk("serial_load", 64'(port_load_rr), 64'b010_010);
      step(0, 4'b0000, 4'b1111);
      chk("serial_drain", 64'(port_load_rr), 64'd0);

      // LOAD balancing: inputs 0,1 end up on port 0, port 1 empty.
      step(1, 4'b0000, 4'b0000);
      step(0, 4'b0001, 4'b0000);
      step(0, 4'b1000, 4'b0000);
      step(0, 4'b0010, 4'b0000);
      step(0, 4'b0000, 4'b1000);
      chk("load_pre", 64'(port_load_ld), 64'b000_010);
      step(0, 4'b0100, 4'b0000);
      chk("load_sel2", 64'(up_sel_ld[2]), 64'd1);
      step(0, 4'b0000, 4'b0011);
      chk("load_dual_rel", 64'(port_load_ld[2:0]), 64'd0);

      // Grant and release on port 0 in the same cycle.
      step(1, 4'b0000, 4'b0000);
      step(0, 4'b0001, 4'b0000);
      step(0, 4'b0010, 4'b0000);
      step(0, 4'b1000, 4'b0001);
      chk("same_cyc_load", 64'(port_load_rr[2:0]), 64'd1);
      chk("same_cyc_valid", 64'(sel_valid_rr), 64'b1010);
      chk("same_cyc_sel3", 64'(up_sel_rr[3]), 64'd0);

      // Tail on idle input, then tail+head on the same idle input.
      step(0, 4'b0000, 4'b0100);
      chk("err_set", 64'(alloc_err_rr), 64'd1);
      chk("err_load", 64'(port_load_rr), 64'b001_001);
      step(0, 4'b0100, 4'b0100);
      chk("err_grant", 64'(sel_valid_ld[2]), 64'd1);
      step(1, 4'b0000, 4'b0000);
      chk("midrst_all", {alloc_err_rr, sel_valid_rr, up_sel_rr,
                         port_load_rr}, 64'd0);

      // Ten grants, each released before the next.
      for (int n = 0; n < 10; n++) begin
         step(0, 4'(1 << (n % 4)), 4'b0000);
         step(0, 4'b0000, 4'(1 << (n % 4)));
      end
`ifdef FATTREE_UPALLOC_STAT_EN
      chk("stat_rr", stat_rr, {32'd5, 32'd5});
`else
      chk("stat_rr", stat_rr, 64'd0);
`endif

      // Random traffic; occasional resets.
      for (int n = 0; n < 300; n++) begin
         h = 4'($urandom_range(0, 15));
         t = 4'($urandom_range(0, 15) & $urandom_range(0, 15));
         step($urandom_range(0, 49) == 0, h, t);
      end

      $display("Simulation finished: %0d checks, %0d errors",
               n_checks, n_errors);
      $finish;
   end

endmodule
